mvu_job_queue: RTL and testbench
================================

# mvu_job_queue

Per-MVU job dispatcher that sits between the host CSR path and the MVU array, taking over the `start`/`done` handshake. Configuration words arrive from the host and are queued per channel in a DEPTH-entry FIFO. Each channel launches its next queued job as soon as its MVU finishes, then holds that job's configuration stable until `done`. Relative to a flat one-job-per-channel config bundle, it adds:
- a parametrised channel count, queue depth and config width;
- back-to-back job chaining;
- a sticky IRQ with write-1-to-clear;
- a per-job watchdog timeout;
- a per-channel queue flush.

## Interface
Parameters:
- NCH, 8, number of MVU channels.
- DEPTH, 4, jobs per channel queue; must be a power of two, ≥2.
- CFGW, 128, width of one packed job configuration word.
- TMOUTW, 24, watchdog counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- push_valid  in  1  host offers a job.
- push_ready  out  1  job accepted when push_valid && push_ready; combinational, equals !full[push_ch] && !flush[push_ch].
- push_ch  in  $clog2(NCH)  target channel.
- push_cfg  in  CFGW  job configuration word.
- flush  in  NCH  per-channel queue flush, level-sampled.
- irq_en  in  NCH  per-channel IRQ enable.
- irq_clr  in  NCH  write-1-to-clear strobe for irq and err.
- timeout  in  TMOUTW  watchdog limit in cycles; 0 disables the watchdog.
- start  out  NCH  one-cycle launch pulse per channel.
- done  in  NCH  MVU job-complete pulse.
- cfg_out  out  NCH*CFGW  active configuration; channel c occupies bits [c*CFGW +: CFGW].
- busy  out  NCH  channel is in LAUNCH or RUN.
- level  out  NCH*($clog2(DEPTH)+1)  queue occupancy per channel.
- irq  out  NCH  sticky completion interrupt.
- err  out  NCH  sticky watchdog-expiry flag.

## Operation
- Each channel has an independent FIFO plus FSM with states IDLE, LAUNCH and RUN.
- IDLE:
  - If the queue is non-empty: pop the head into the cfg_out register and go to LAUNCH.
  - Otherwise hold cfg_out at its last value.
- LAUNCH:
  - start[c]=1 for exactly this one cycle.
  - Clear the watchdog counter.
  - Go to RUN.
- RUN:
  - done[c]=1 → IDLE, and set irq[c] if irq_en[c].
  - Else if timeout≠0 and the counter equals timeout-1 → IDLE, and set err[c].
  - Else increment the counter (saturating at all-ones).
- The counter counts RUN cycles only. The cycle spent in LAUNCH is not counted.
- done[c] in IDLE or LAUNCH is ignored: no state change, no irq.
- Simultaneous done and watchdog expiry: done wins and err is not set.
- cfg_out[c] is stable from the LAUNCH cycle until the next pop. It never changes during RUN.
- The push path has no bypass: a job pushed into an empty queue is written first and popped on the following edge.
- Full queue:
  - push_ready is low, even if a pop occurs in the same cycle.
  - No data is lost; the host retries.
- flush[c]:
  - Empties queue c on that edge (level becomes 0) and rejects any push to c in that cycle.
  - Does not abort a job in LAUNCH or RUN. The running job completes normally.
- irq/err clear vs set: if set and irq_clr hit the same bit in the same cycle, set wins.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from level.

## Timing
- Reset values:
  - all FSMs IDLE;
  - all queues empty (level=0);
  - start=0, busy=0, irq=0, err=0, cfg_out=0;
  - watchdog counters 0.
- Asserting rst_n mid-job drops all queued and running jobs immediately. No start pulse is emitted after reset release until a new push.
- Push handshake at edge k (channel idle, queue empty):
  - pop at edge k+1;
  - start and the new cfg_out are visible in cycle k+1→k+2;
  - busy rises at edge k+1.
- done sampled at edge d with the queue non-empty:
  - IDLE at d;
  - pop at d+1;
  - start in cycle d+1→d+2.
  - Minimum done-to-start gap is therefore 1 idle cycle.
- irq/err rise at the same edge the FSM leaves RUN.
- level updates on the push/pop edge. A simultaneous push and pop keeps level unchanged.
- push_ready is combinational from push_ch, flush and level. It has no dependency on push_valid.

## Test plan
- Single job: push ch2 cfg=0xA5…A5 → start[2] one cycle after the handshake, cfg_out[2]=0xA5…A5, busy[2]=1; done[2] 10 cycles later → busy 0, irq[2]=1 (irq_en[2]=1).
- Queue fill and chaining: push 4 jobs to ch0 while it is RUNning → level=4 and push_ready=0 for ch0 only; 5th push stalls. Then pulse done 4 times → 4 start pulses, each 2 cycles after its done, with cfg_out in push order.
- Watchdog: timeout=16, no done → err[c] set 16 cycles after LAUNCH, FSM returns to IDLE and the next queued job launches. Repeat with done on cycle 16 → irq set, err clear.
- Sticky flags: irq_clr on the same cycle as done → irq remains 1; irq_clr on the next cycle → irq=0.
- Flush: ch1 RUN with level=3, flush[1] plus a simultaneous push to ch1 → push_ready=0, level=0, running job still completes on done, no further start.
- Reset mid-RUN: rst_n low for 1 cycle with level=2 → all outputs return to reset values, no start after release.

Source files
------------

// File: rtl/mvu_job_queue.sv
`default_nettype none
// ============================================================================
// Module   : mvu_job_queue
// Purpose  : Per-MVU job dispatcher. Host job words are queued per channel in
//            a DEPTH-entry FIFO. Each channel launches its next job as soon as
//            its MVU is free, then holds that job's configuration stable until
//            done. It also provides a sticky IRQ, a watchdog error flag and a
//            per-channel queue flush.
// Ports    : clk, rst_n                   - clock, async active-low reset
//            push_valid/ready/ch/cfg      - host job push handshake
//            flush[NCH]                   - per-channel queue flush (level)
//            irq_en[NCH], irq_clr[NCH]    - IRQ enable, W1C for irq and err
//            timeout[TMOUTW]              - watchdog limit, 0 = disabled
//            start[NCH], done[NCH]        - MVU launch pulse / completion
//            cfg_out[NCH*CFGW]            - active job configuration
//            busy, level, irq, err        - per-channel status
// Revision : 1.0 - initial release
// ============================================================================
module mvu_job_queue #(
    parameter int NCH    = 8,
    parameter int DEPTH  = 4,
    parameter int CFGW   = 128,
    parameter int TMOUTW = 24
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push_valid,
    output logic                                 push_ready,
    input  logic [$clog2(NCH)-1:0]               push_ch,
    input  logic [CFGW-1:0]                      push_cfg,
    input  logic [NCH-1:0]                       flush,
    input  logic [NCH-1:0]                       irq_en,
    input  logic [NCH-1:0]                       irq_clr,
    input  logic [TMOUTW-1:0]                    timeout,
    output logic [NCH-1:0]                       start,
    input  logic [NCH-1:0]                       done,
    output logic [NCH*CFGW-1:0]                  cfg_out,
    output logic [NCH-1:0]                       busy,
    output logic [NCH*($clog2(DEPTH)+1)-1:0]     level,
    output logic [NCH-1:0]                       irq,
    output logic [NCH-1:0]                       err
);

    localparam int CHW = $clog2(NCH);
    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Per-channel decode of the push target and queue-full status. An
    // out-of-range push_ch hits no channel, so push_ready stays low for it.
    logic [NCH-1:0] w_hit;
    logic [NCH-1:0] w_full;

    assign push_ready = |(w_hit & ~w_full & ~flush);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CFGW-1:0]   r_mem [DEPTH];
        logic [PW-1:0]     r_wr_ptr;
        logic [PW-1:0]     r_rd_ptr;
        logic [LW-1:0]     r_level;
        state_t            r_state;
        logic [TMOUTW-1:0] r_wdog;
        logic [CFGW-1:0]   r_cfg;
        logic              r_start;
        logic              r_busy;
        logic              r_irq;
        logic              r_err;

        logic w_push;
        logic w_pop;
        logic w_wdog_exp;
        logic w_irq_set;
        logic w_err_set;

        assign w_hit[c]  = (push_ch == CHW'(c));
        assign w_full[c] = (r_level == LW'(DEPTH));

        assign w_push = push_valid & w_hit[c] & ~w_full[c] & ~flush[c];
        // A flush discards the queue on this edge, so it also suppresses a pop.
        assign w_pop  = (r_state == ST_IDLE) & (r_level != '0) & ~flush[c];

        assign w_wdog_exp = (timeout != '0) && (r_wdog == timeout - TMOUTW'(1));
        // done has priority over a coincident watchdog expiry.
        assign w_irq_set  = (r_state == ST_RUN) & done[c] & irq_en[c];
        assign w_err_set  = (r_state == ST_RUN) & ~done[c] & w_wdog_exp;

        // Queue storage carries no reset: entries are only read after a push.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_cfg;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else if (flush[c]) begin
                r_rd_ptr <= r_wr_ptr;
                r_level  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_level <= r_level + LW'(w_push) - LW'(w_pop);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_wdog  <= '0;
                r_cfg   <= '0;
                r_start <= 1'b0;
                r_busy  <= 1'b0;
                r_irq   <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                // Set beats a same-cycle clear.
                r_irq <= (r_irq & ~irq_clr[c]) | w_irq_set;
                r_err <= (r_err & ~irq_clr[c]) | w_err_set;

                case (r_state)
                    ST_IDLE: begin
                        r_start <= 1'b0;
                        if (w_pop) begin
                            r_cfg   <= r_mem[r_rd_ptr];
                            r_start <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= ST_LAUNCH;
                        end
                    end
                    ST_LAUNCH: begin
                        // The launch cycle itself is not counted by the watchdog.
                        r_start <= 1'b0;
                        r_wdog  <= '0;
                        r_state <= ST_RUN;
                    end
                    ST_RUN: begin
                        r_start <= 1'b0;
                        if (done[c] || w_wdog_exp) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (r_wdog != '1) begin
                            r_wdog <= r_wdog + 1'b1;
                        end
                    end
                    default: begin
                        r_start <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end

        assign start[c]                 = r_start;
        assign busy[c]                  = r_busy;
        assign irq[c]                   = r_irq;
        assign err[c]                   = r_err;
        assign cfg_out[c*CFGW +: CFGW]  = r_cfg;
        assign level[c*LW +: LW]        = r_level;
    end

endmodule
`default_nettype wire

// File: tb/tb_mvu_job_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvu_job_queue
// Purpose  : Self-checking bench for mvu_job_queue. A per-cycle vector table
//            covers a single job, chained jobs and sticky IRQ behaviour on
//            channel 2; directed sequences cover queue fill and chaining,
//            watchdog expiry, flush and reset mid-job.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mvu_job_queue;

    localparam int NCH    = 8;
    localparam int DEPTH  = 4;
    localparam int CFGW   = 128;
    localparam int TMOUTW = 24;
    localparam int LW     = 3;

    logic                clk;
    logic                rst_n;
    logic                push_valid;
    logic                push_ready;
    logic [2:0]          push_ch;
    logic [CFGW-1:0]     push_cfg;
    logic [NCH-1:0]      flush;
    logic [NCH-1:0]      irq_en;
    logic [NCH-1:0]      irq_clr;
    logic [TMOUTW-1:0]   timeout;
    logic [NCH-1:0]      start;
    logic [NCH-1:0]      done;
    logic [NCH*CFGW-1:0] cfg_out;
    logic [NCH-1:0]      busy;
    logic [NCH*LW-1:0]   level;
    logic [NCH-1:0]      irq;
    logic [NCH-1:0]      err;

    int errors = 0;
    int checks = 0;

    mvu_job_queue #(
        .NCH(NCH), .DEPTH(DEPTH), .CFGW(CFGW), .TMOUTW(TMOUTW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_ch(push_ch), .push_cfg(push_cfg),
        .flush(flush), .irq_en(irq_en), .irq_clr(irq_clr),
        .timeout(timeout), .start(start), .done(done),
        .cfg_out(cfg_out), .busy(busy), .level(level),
        .irq(irq), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       pv;
        logic [2:0] pch;
        logic [7:0] pb;
        logic [7:0] dn;
        logic [7:0] clr;
        logic [7:0] e_start;
        logic [7:0] e_busy;
        logic [7:0] e_irq;
        logic       e_ready;
        logic [2:0] e_lvl;
        logic [7:0] e_cfg;
    } vec_t;

    vec_t tv [20];

    function automatic logic [CFGW-1:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [LW-1:0] lvl(input int c);
        return level[c*LW +: LW];
    endfunction

    function automatic logic [CFGW-1:0] cfgc(input int c);
        return cfg_out[c*CFGW +: CFGW];
    endfunction

    task automatic chk(input string name, input logic [CFGW-1:0] act,
                       input logic [CFGW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        push_valid = 1'b0;
        push_cfg   = '0;
        done       = '0;
        flush      = '0;
        irq_clr    = '0;
    endtask

    logic [7:0] seen;

    initial begin
        rst_n      = 1'b0;
        push_ch    = 3'd0;
        irq_en     = '1;
        timeout    = '0;
        idle_inputs();

        // Per-cycle table on channel 2 (cfg byte is replicated across the word).
        //          pv  pch   pb     dn     clr    start  busy   irq    rdy lvl cfg
        tv[0]  = '{1'b1,3'd2,8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,1'b1,3'd0,8'h00};
        tv[1]  = '{1'b0,3'd2,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,1'b1,3'd1,8'h00};
        tv[2]  = '{1'b0,3'd2,8'h00,8'h00,8'h00,8'h04,8'h04,8'h00,1'b1,3'd0,8'hA5};
        tv[3]  = '{1'b0,3'd2,8'h00,8'h00,8'h00,8'h00,8'h04,8'h00,1'b1,3'd0,8'hA5};
        tv[4]  = '{1'b0,3'd2,8'h00,8'h00,8'h00,8'h00,8'h04,8'h00,1'b1,3'd0,8'hA5};
        tv[5]  = '{1'b0,3'd2,8'h00,8'h04,8'h00,8'h00,8'h04,8'h00,1'b1,3'd0,8'hA5};
        tv[6]  = '{1'b0,3'd2,8'h00,8'h00,8'h00,8'h00,8'h00,8'h04,1'b1,3'd0,8'hA5};
        tv[7]  = '{1'b0,3'd2,8'h00,8'h00,8'h04,8'h00,8'h00,8'h04,1'b1,3'd0,8'hA5};
        tv[8]  = '{1'b0,3'd2,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,1'b1,3'd0,8'hA5};
        tv[9]  = '{1'b1,3'd2,8'h3C,8'h00,8'h00,8'h00,8'h00,8'h00,1'b1,3'd0,8'hA5};
        tv[10] = '{1'b1,3'd2,8'h5A,8'h00,8'h00,8'h00,8'h00,8'h00,1'b1,3'd1,8'hA5};
        tv[11] = '{1'b0,3'd2,8'h00,8'h04,8'h00,8'h04,8'h04,8'h00,1'b1,3'd1,8'h3C};
        tv[12] = '{1'b0,3'd2,8'h00,8'h00,8'h00,8'h00,8'h04,8'h00,1'b1,3'd1,8'h3C};
        tv[13] = '{1'b0,3'd2,8'h00,8'h04,8'h04,8'h00,8'h04,8'h00,1'b1,3'd1,8'h3C};
        tv[14] = '{1'b0,3'd2,8'h00,8'h00,8'h00,8'h00,8'h00,8'h04,1'b1,3'd1,8'h3C};
        tv[15] = '{1'b0,3'd2,8'h00,8'h00,8'h00,8'h04,8'h04,8'h04,1'b1,3'd0,8'h5A};
        tv[16] = '{1'b0,3'd2,8'h00,8'h00,8'h04,8'h00,8'h04,8'h04,1'b1,3'd0,8'h5A};
        tv[17] = '{1'b0,3'd2,8'h00,8'h00,8'h00,8'h00,8'h04,8'h00,1'b1,3'd0,8'h5A};
        tv[18] = '{1'b0,3'd2,8'h00,8'h04,8'h00,8'h00,8'h04,8'h00,1'b1,3'd0,8'h5A};
        tv[19] = '{1'b0,3'd2,8'h00,8'h00,8'h00,8'h00,8'h00,8'h04,1'b1,3'd0,8'h5A};

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_start", start, '0);
        chk("rst_busy", busy, '0);
        chk("rst_level", level, '0);
        chk("rst_irq", irq, '0);
        chk("rst_err", err, '0);
        chk("rst_cfg_ch0", cfgc(0), '0);
        rst_n = 1'b1;
        step();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 20; i++) begin
            push_valid = tv[i].pv;
            push_ch    = tv[i].pch;
            push_cfg   = rep(tv[i].pb);
            done       = tv[i].dn;
            irq_clr    = tv[i].clr;
            #1;
            chk($sformatf("row%0d start", i), start, tv[i].e_start);
            chk($sformatf("row%0d busy", i), busy, tv[i].e_busy);
            chk($sformatf("row%0d irq", i), irq, tv[i].e_irq);
            chk($sformatf("row%0d err", i), err, '0);
            chk($sformatf("row%0d ready", i), push_ready, tv[i].e_ready);
            chk($sformatf("row%0d level2", i), lvl(2), tv[i].e_lvl);
            chk($sformatf("row%0d cfg2", i), cfgc(2), rep(tv[i].e_cfg));
            step();
        end
        idle_inputs();
        step();

        // ---------------- queue fill and chaining on ch0 ----------------
        push_valid = 1'b1; push_ch = 3'd0; push_cfg = rep(8'h01);
        step();
        push_valid = 1'b0;
        step();
        chk("chain_j0_start", start[0], 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1; push_ch = 3'd0; push_cfg = rep(8'h10 + 8'(i));
            step();
        end
        push_cfg = rep(8'hEE);
        #1;
        chk("chain_full_ready_ch0", push_ready, 1'b0);
        chk("chain_full_level", lvl(0), 3'd4);
        push_ch = 3'd1;
        #1;
        chk("chain_full_ready_ch1", push_ready, 1'b1);
        push_ch = 3'd0;
        step();
        step();
        chk("chain_stall_level", lvl(0), 3'd4);
        chk("chain_stall_busy", busy[0], 1'b1);
        push_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            done[0] = 1'b1;
            step();
            done[0] = 1'b0;
            chk($sformatf("chain%0d gap_start", i), start[0], 1'b0);
            chk($sformatf("chain%0d gap_busy", i), busy[0], 1'b0);
            step();
            chk($sformatf("chain%0d start", i), start[0], 1'b1);
            chk($sformatf("chain%0d cfg", i), cfgc(0), rep(8'h10 + 8'(i)));
            chk($sformatf("chain%0d level", i), lvl(0), 3'(3 - i));
            step();
            chk($sformatf("chain%0d pulse_end", i), start[0], 1'b0);
        end
        done[0] = 1'b1;
        step();
        done[0] = 1'b0;
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen |= start;
        end
        chk("chain_no_extra_start", seen[0], 1'b0);
        chk("chain_end_busy", busy[0], 1'b0);

        // ---------------- watchdog on ch3 ----------------
        timeout = 24'd16;
        push_valid = 1'b1; push_ch = 3'd3; push_cfg = rep(8'h51);
        step();
        push_cfg = rep(8'h52);
        step();
        push_valid = 1'b0;
        chk("wd_a_start", start[3], 1'b1);
        chk("wd_a_cfg", cfgc(3), rep(8'h51));
        for (int k = 1; k <= 16; k++) step();
        chk("wd_a_err_before", err[3], 1'b0);
        chk("wd_a_busy_before", busy[3], 1'b1);
        step();
        chk("wd_a_err_set", err[3], 1'b1);
        chk("wd_a_idle", busy[3], 1'b0);
        step();
        chk("wd_b_start", start[3], 1'b1);
        chk("wd_b_cfg", cfgc(3), rep(8'h52));
        irq_clr[3] = 1'b1;
        step();
        irq_clr[3] = 1'b0;
        chk("wd_err_cleared", err[3], 1'b0);
        for (int k = 2; k <= 16; k++) step();
        done[3] = 1'b1;
        chk("wd_b_busy_before", busy[3], 1'b1);
        step();
        done[3] = 1'b0;
        chk("wd_b_irq", irq[3], 1'b1);
        chk("wd_b_err_clear", err[3], 1'b0);
        chk("wd_b_idle", busy[3], 1'b0);
        timeout = '0;
        step();

        // ---------------- flush on ch1 ----------------
        push_valid = 1'b1; push_ch = 3'd1; push_cfg = rep(8'h61);
        step();
        push_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1; push_cfg = rep(8'h62 + 8'(i));
            step();
        end
        chk("flush_pre_level", lvl(1), 3'd3);
        flush[1] = 1'b1; push_cfg = rep(8'h77);
        #1;
        chk("flush_ready", push_ready, 1'b0);
        step();
        flush[1] = 1'b0; push_valid = 1'b0;
        chk("flush_level", lvl(1), 3'd0);
        chk("flush_busy", busy[1], 1'b1);
        done[1] = 1'b1;
        step();
        done[1] = 1'b0;
        chk("flush_done_idle", busy[1], 1'b0);
        chk("flush_done_irq", irq[1], 1'b1);
        chk("flush_cfg_hold", cfgc(1), rep(8'h61));
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen |= start;
        end
        chk("flush_no_start", seen[1], 1'b0);

        // ---------------- reset mid-RUN on ch4 ----------------
        push_valid = 1'b1; push_ch = 3'd4; push_cfg = rep(8'h81);
        step();
        push_cfg = rep(8'h82);
        step();
        push_cfg = rep(8'h83);
        step();
        push_valid = 1'b0;
        chk("rstmid_level", lvl(4), 3'd2);
        chk("rstmid_busy", busy[4], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_start", start, '0);
        chk("rstmid_busy0", busy, '0);
        chk("rstmid_level0", level, '0);
        chk("rstmid_irq", irq, '0);
        chk("rstmid_err", err, '0);
        chk("rstmid_cfg4", cfgc(4), '0);
        step();
        rst_n = 1'b1;
        seen = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen |= start;
        end
        chk("rstmid_no_start", seen, '0);
        chk("rstmid_still_idle", busy, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
